// File: rtl/md5_avalon_host_pkg.sv
// Shared definitions for the MD5 control-slave Avalon-MM host:
// register map, mask width and host FSM states.
package md5_avalon_pkg;

  localparam int unsigned MASK_W = 32;

  localparam logic [1:0] ADDR_RESET = 2'd0;
  localparam logic [1:0] ADDR_START = 2'd1;
  localparam logic [1:0] ADDR_DONE  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_RST,
    ST_WR_START,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_GAP,
    ST_WR_CLR,
    ST_RESP
  } state_t;

endpackage

// File: rtl/md5_avalon_host.sv
// Avalon-MM initiator that resets, starts, polls and releases a masked group
// of MD5 cores, then reports the done vector, poll count and timeout.
module md5_avalon_host
  import md5_avalon_pkg::*;
#(
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MASK_W-1:0] cmd_mask,
  output logic              rsp_valid,
  output logic [MASK_W-1:0] rsp_done,
  output logic              rsp_timeout,
  output logic [15:0]       rsp_polls,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [MASK_W-1:0] avm_writedata,
  input  logic [MASK_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  state_t            r_state;
  state_t            w_next;
  logic [MASK_W-1:0] r_mask;
  logic [MASK_W-1:0] r_done;
  logic              r_timeout;
  logic [15:0]       r_poll_cnt;
  logic [7:0]        r_gap_cnt;
  logic [MASK_W-1:0] r_rsp_done;
  logic [15:0]       r_rsp_polls;
  logic              r_rsp_timeout;
  logic [MASK_W-1:0] w_rd_done;
  logic              w_finish;

  assign w_rd_done = avm_readdata & r_mask;
  assign w_finish  = (w_rd_done == r_mask) || (r_poll_cnt == 16'(MAX_POLLS));

  assign cmd_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_done    = r_rsp_done;
  assign rsp_polls   = r_rsp_polls;
  assign rsp_timeout = r_rsp_timeout;

  always_comb begin
    w_next        = r_state;
    avm_address   = ADDR_RESET;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) w_next = (cmd_mask == '0) ? ST_RESP : ST_WR_RST;
      end
      ST_WR_RST: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_RESET;
        avm_writedata = r_mask;
        if (!avm_waitrequest) w_next = ST_WR_START;
      end
      ST_WR_START: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_START;
        avm_writedata = r_mask;
        if (!avm_waitrequest) w_next = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        avm_read    = 1'b1;
        avm_address = ADDR_DONE;
        if (!avm_waitrequest) w_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (avm_readdatavalid) begin
          if (w_finish)           w_next = ST_WR_CLR;
          else if (POLL_GAP == 0) w_next = ST_RD_REQ;
          else                    w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt <= 8'd1) w_next = ST_RD_REQ;
      end
      ST_WR_CLR: begin
        avm_write   = 1'b1;
        avm_address = ADDR_START;
        if (!avm_waitrequest) w_next = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mask        <= '0;
      r_done        <= '0;
      r_timeout     <= 1'b0;
      r_poll_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_rsp_done    <= '0;
      r_rsp_polls   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_mask    <= cmd_mask;
            r_done    <= '0;
            r_timeout <= 1'b0;
            // An empty mask skips the bus entirely, so its response is loaded here.
            if (cmd_mask == '0) begin
              r_rsp_done    <= '0;
              r_rsp_polls   <= '0;
              r_rsp_timeout <= 1'b0;
            end
          end
        end
        ST_WR_START: if (!avm_waitrequest) r_poll_cnt <= '0;
        ST_RD_REQ: begin
          if (!avm_waitrequest && (r_poll_cnt != '1)) r_poll_cnt <= r_poll_cnt + 16'd1;
        end
        ST_RD_WAIT: begin
          if (avm_readdatavalid) begin
            r_done    <= w_rd_done;
            r_timeout <= (w_rd_done != r_mask);
            r_gap_cnt <= 8'(POLL_GAP);
          end
        end
        ST_GAP: r_gap_cnt <= r_gap_cnt - 8'd1;
        ST_WR_CLR: begin
          if (!avm_waitrequest) begin
            r_rsp_done    <= r_done;
            r_rsp_polls   <= r_poll_cnt;
            r_rsp_timeout <= r_timeout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_avalon_host.sv
// Directed bench for md5_avalon_host with a behavioural Avalon control slave.
module tb_md5_avalon_host;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic [31:0] rsp_done;
  logic        rsp_timeout;
  logic [15:0] rsp_polls;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;

  md5_avalon_host #(.POLL_GAP(4), .MAX_POLLS(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_mask          (cmd_mask),
    .rsp_valid         (rsp_valid),
    .rsp_done          (rsp_done),
    .rsp_timeout       (rsp_timeout),
    .rsp_polls         (rsp_polls),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Slave configuration (written by the stimulus) and observation logs (written by the slave).
  int unsigned wait_n = 0;
  logic [31:0] rd_tab[8];
  int          rd_len = 1;
  int          rd_base = 0;

  logic        lg_wr[$];
  logic [1:0]  lg_addr[$];
  logic [31:0] lg_data[$];
  int          rdv_cyc[$];
  int          rds_cyc[$];
  int          rdv_cnt = 0;
  int          stab_err = 0;

  logic        req_act = 1'b0;
  logic        rd_pend = 1'b0;
  int unsigned wait_left = 0;
  logic        s_rd, s_wr;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  int          s_idx;

  // Control slave: stalls each request wait_n cycles, returns read data one cycle after accept.
  always @(negedge clk) begin
    if (reset) begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      req_act           = 1'b0;
      rd_pend           = 1'b0;
    end else begin
      avm_readdatavalid = 1'b0;
      if (rd_pend) begin
        s_idx = rdv_cnt - rd_base;
        avm_readdata      = (s_idx < rd_len) ? rd_tab[s_idx] : rd_tab[rd_len-1];
        avm_readdatavalid = 1'b1;
        rdv_cyc.push_back(cyc);
        rdv_cnt++;
        rd_pend = 1'b0;
      end
      if (avm_read && avm_write) stab_err++;
      if (avm_read || avm_write) begin
        if (!req_act) begin
          req_act   = 1'b1;
          wait_left = wait_n;
          s_rd = avm_read; s_wr = avm_write; s_addr = avm_address; s_data = avm_writedata;
          if (avm_read) rds_cyc.push_back(cyc);
        end else if (s_rd !== avm_read || s_wr !== avm_write ||
                     s_addr !== avm_address || (s_wr && s_data !== avm_writedata)) begin
          stab_err++;
        end
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm_waitrequest = 1'b0;
          req_act = 1'b0;
          lg_wr.push_back(avm_write);
          lg_addr.push_back(avm_address);
          lg_data.push_back(avm_write ? avm_writedata : 32'h0);
          if (avm_read) rd_pend = 1'b1;
        end
      end else begin
        if (req_act) stab_err++;
        avm_waitrequest = 1'b0;
        req_act = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_x(input string tag, input int i, input logic wr,
                       input logic [1:0] a, input logic [31:0] d);
    chk({tag, "_kind"}, {29'd0, lg_wr[i], lg_addr[i]}, {29'd0, wr, a});
    if (wr) chk({tag, "_data"}, lg_data[i], d);
  endtask

  // Issues one job and returns the accept-to-rsp_valid latency (-1 if none within budget).
  task automatic run_job(input logic [31:0] mask, output int lat);
    int c0;
    @(negedge clk);
    chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_mask  = mask;
    c0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_mask  = '0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_seen", {31'd0, (lat >= 0)}, 32'd1);
    @(negedge clk);
    chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int lat, lb, rb, vb, se, nrd, c0;
    logic seen;
    reset = 1'b1; cmd_valid = 1'b0; cmd_mask = '0;
    avm_readdata = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    rd_tab[0] = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_done", rsp_done, 32'd0);
    chk("rst_rsp_polls", {16'd0, rsp_polls}, 32'd0);
    chk("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    chk("rst_addr_data", avm_writedata | {30'd0, avm_address}, 32'd0);
    #2 reset = 1'b0;

    // Test 1: mask 5, done on first poll.
    wait_n = 0; rd_tab[0] = 32'h5; rd_len = 1; rd_base = rdv_cnt;
    lb = lg_wr.size(); se = stab_err;
    run_job(32'h5, lat);
    chk("t1_lat", lat, 32'd6);
    chk("t1_done", rsp_done, 32'h5);
    chk("t1_polls", {16'd0, rsp_polls}, 32'd1);
    chk("t1_tmo", {31'd0, rsp_timeout}, 32'd0);
    chk("t1_nxfer", lg_wr.size() - lb, 32'd4);
    chk_x("t1_x0", lb, 1'b1, 2'd0, 32'h5);
    chk_x("t1_x1", lb + 1, 1'b1, 2'd1, 32'h5);
    chk_x("t1_x2", lb + 2, 1'b0, 2'd2, 32'h0);
    chk_x("t1_x3", lb + 3, 1'b1, 2'd1, 32'h0);
    chk("t1_stab", stab_err - se, 32'd0);

    // Test 2: mask 3, done 1,1,3 with POLL_GAP = 4.
    rd_tab[0] = 32'h1; rd_tab[1] = 32'h1; rd_tab[2] = 32'h3; rd_len = 3; rd_base = rdv_cnt;
    lb = lg_wr.size(); rb = rds_cyc.size(); vb = rdv_cyc.size();
    run_job(32'h3, lat);
    chk("t2_lat", lat, 32'd18);
    chk("t2_done", rsp_done, 32'h3);
    chk("t2_polls", {16'd0, rsp_polls}, 32'd3);
    chk("t2_tmo", {31'd0, rsp_timeout}, 32'd0);
    chk("t2_nxfer", lg_wr.size() - lb, 32'd6);
    chk("t2_gap1", rds_cyc[rb+1] - rdv_cyc[vb], 32'd5);
    chk("t2_gap2", rds_cyc[rb+2] - rdv_cyc[vb+1], 32'd5);
    chk_x("t2_last", lb + 5, 1'b1, 2'd1, 32'h0);

    // Test 3: every request stalled 3 cycles.
    wait_n = 3; rd_tab[0] = 32'h5; rd_len = 1; rd_base = rdv_cnt;
    lb = lg_wr.size(); se = stab_err;
    run_job(32'h5, lat);
    chk("t3_lat", lat, 32'd18);
    chk("t3_done", rsp_done, 32'h5);
    chk("t3_polls", {16'd0, rsp_polls}, 32'd1);
    chk("t3_nxfer", lg_wr.size() - lb, 32'd4);
    chk_x("t3_x0", lb, 1'b1, 2'd0, 32'h5);
    chk_x("t3_x1", lb + 1, 1'b1, 2'd1, 32'h5);
    chk_x("t3_x2", lb + 2, 1'b0, 2'd2, 32'h0);
    chk_x("t3_x3", lb + 3, 1'b1, 2'd1, 32'h0);
    chk("t3_stab", stab_err - se, 32'd0);

    // Test 4: never done (bits outside the mask set) -> timeout after MAX_POLLS = 8.
    wait_n = 0; rd_tab[0] = 32'hFFFF_FF00; rd_len = 1; rd_base = rdv_cnt;
    lb = lg_wr.size();
    run_job(32'hFF, lat);
    chk("t4_lat", lat, 32'd48);
    chk("t4_done", rsp_done, 32'h0);
    chk("t4_polls", {16'd0, rsp_polls}, 32'd8);
    chk("t4_tmo", {31'd0, rsp_timeout}, 32'd1);
    chk("t4_nxfer", lg_wr.size() - lb, 32'd11);
    nrd = 0;
    for (int i = lb; i < lg_wr.size(); i++) if (!lg_wr[i] && lg_addr[i] == 2'd2) nrd++;
    chk("t4_nreads", nrd, 32'd8);
    chk_x("t4_last", lb + 10, 1'b1, 2'd1, 32'h0);

    // Test 6: reset while waiting for read data, then a normal job.
    rd_tab[0] = 32'h1; rd_len = 1; rd_base = rdv_cnt;
    lb = lg_wr.size();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mask = 32'h1; c0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_mask = '0;
    repeat (3) @(negedge clk);
    chk("t6_pre_cyc", cyc - c0, 32'd4);
    chk("t6_pre_nxfer", lg_wr.size() - lb, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t6_rsp_tmo", {31'd0, rsp_timeout}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("t6_no_rsp", {31'd0, seen}, 32'd0);
    rd_tab[0] = 32'h5; rd_len = 1; rd_base = rdv_cnt;
    lb = lg_wr.size();
    run_job(32'h5, lat);
    chk("t6_lat", lat, 32'd6);
    chk("t6_done", rsp_done, 32'h5);
    chk("t6_nxfer", lg_wr.size() - lb, 32'd4);

    // Test 5: empty mask, no bus traffic, response one cycle after accept.
    lb = lg_wr.size(); rb = rds_cyc.size();
    run_job(32'h0, lat);
    chk("t5_lat", lat, 32'd1);
    chk("t5_done", rsp_done, 32'h0);
    chk("t5_polls", {16'd0, rsp_polls}, 32'd0);
    chk("t5_nxfer", lg_wr.size() - lb, 32'd0);
    chk("t5_nreads", rds_cyc.size() - rb, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/md5_avalon_host.md
Name: md5_avalon_host

Overview:
- Avalon-MM initiator that drives the MD5 control/status slave: reset, start, done-polling and release of a group of MD5 cores.
- Accepts one job (a 32-bit core mask) on a valid/ready command port and issues the fixed register sequence: reset mask, start mask, poll done, clear start.
- Returns the done vector, poll count and timeout flag on a one-cycle response strobe.
- Sits between the test/sequencer logic and the control-slave port of the MD5 array, in place of a soft processor.

Parameters:
- POLL_GAP, 4: idle cycles between the end of one done-read and the next read issue. Range 0..255.
- MAX_POLLS, 1024: done-reads allowed before the job is declared timed out. Range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  block idle; job accepted when cmd_valid && cmd_ready
- cmd_mask  in  32  cores to run, one bit per core
- rsp_valid  out  1  one-cycle pulse: job finished
- rsp_done  out  32  last done vector read, ANDed with the mask
- rsp_timeout  out  1  job ended on MAX_POLLS
- rsp_polls  out  16  number of done-reads issued
- avm_address  out  2  word address: 0 = reset reg, 1 = start reg, 2 = done reg
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data valid

Behaviour:
- Clock and reset: one clock domain (clk). reset is asynchronous and active-high.
- Reset values: all outputs 0 except cmd_ready = 1. State IDLE; counters and the mask register cleared. A reset mid-job aborts the job immediately; no response is issued.
- Avalon rules:
  - A request holds address, read/write and writedata stable while avm_waitrequest = 1. It completes on the first cycle avm_waitrequest = 0.
  - At most one read is outstanding. read and write are never high together.
  - avm_readdatavalid is ignored outside RD_WAIT.
- States:
  - IDLE: cmd_ready = 1. On accept, latch the mask into mask_q.
    - mask = 0: go to RESP with rsp_done = 0, polls = 0, timeout = 0. No bus traffic.
    - Otherwise go to WR_RST.
  - WR_RST: write mask_q to address 0. On completion, go to WR_START.
  - WR_START: write mask_q to address 1. This write also releases the slave's reset register. On completion, clear poll_cnt and go to RD_REQ.
  - RD_REQ: read address 2. On completion, increment poll_cnt and go to RD_WAIT.
  - RD_WAIT: wait for avm_readdatavalid. On valid, capture done_q = readdata & mask_q.
    - done_q == mask_q: go to WR_CLR, timeout = 0.
    - Else if poll_cnt == MAX_POLLS: go to WR_CLR, timeout = 1.
    - Else load gap_cnt = POLL_GAP and go to GAP. With POLL_GAP = 0, go straight to RD_REQ.
  - GAP: decrement gap_cnt each cycle; at 1, go to RD_REQ. The next read asserts exactly POLL_GAP cycles after the readdatavalid cycle, plus one.
  - WR_CLR: write 0 to address 1, which deasserts start. On completion, go to RESP.
  - RESP: rsp_valid = 1 for one cycle. rsp_done, rsp_timeout and rsp_polls are valid with it and hold until the next job ends. Return to IDLE.
- Latency with zero waitrequest and 1-cycle read latency, done on the first poll: accept → WR_RST 1 → WR_START 1 → RD_REQ 1 → RD_WAIT 1 → WR_CLR 1 → rsp_valid. rsp_valid occurs 6 cycles after the accept cycle.
- Bits of avm_readdata outside the mask are ignored.
- poll_cnt saturates at 65535.
- A readdatavalid arriving in the same cycle as the read issue is not legal; it is not handled.

Decomposition:
- Shared package md5_avalon_pkg:
  - register address constants: ADDR_RESET = 0, ADDR_START = 1, ADDR_DONE = 2
  - state enumeration
  - the 32-bit mask width constant
- Sub-module: none. The FSM and two counters stay in one module.

Test Plan:
- mask 0x0000_0005, waitrequest 0, done = 0x5 on the first read → bus: write 0x5@0, write 0x5@1, read@2, write 0x0@1. rsp_valid 6 cycles after accept; rsp_done = 0x5, rsp_polls = 1, rsp_timeout = 0.
- mask 0x3, done returns 0x1, 0x1, then 0x3; POLL_GAP = 4 → 3 reads, each issued 5 cycles after the prior readdatavalid. rsp_polls = 3, rsp_done = 0x3.
- waitrequest held 3 cycles on every request → address, data and strobes stable throughout. The sequence and response match the first test, each bus request stretched by 3 cycles.
- MAX_POLLS = 8, done always 0x0, mask 0xFF → 8 reads, then the clear write. rsp_timeout = 1, rsp_polls = 8, rsp_done = 0.
- cmd_mask = 0 → no bus activity. rsp_valid 1 cycle after accept, rsp_done = 0.
- reset asserted during RD_WAIT → next cycle: all bus strobes 0, cmd_ready = 1, no rsp_valid. The next job runs normally.
